// File: rtl/e15_run_ctrl.sv
// Run controller for a small processor: ROM loading, RUN/STEP/HALT sequencing, and stop-cause tracking.
// Define E15_BKPT_EN to add the single-address breakpoint (ports bkpt_en, bkpt_addr).
module e15_run_ctrl #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       ld_addr,
  input  logic [11:0]      ld_data,
  output logic             rom_we,
  output logic [3:0]       rom_waddr,
  output logic [11:0]      rom_wdata,
  input  logic [3:0]       core_pc,
  input  logic [11:0]      core_instr,
  output logic             core_en,
  output logic             busy,
  output logic             stop_pulse,
  output logic [2:0]       stop_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             cmd_err
`ifdef E15_BKPT_EN
  ,
  input  logic             bkpt_en,
  input  logic [3:0]       bkpt_addr
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_STEP, S_STOPPED} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [2:0] CAUSE_NONE    = 3'b000;
  localparam logic [2:0] CAUSE_STEP    = 3'b001;
  localparam logic [2:0] CAUSE_HINSTR  = 3'b010;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'b011;
  localparam logic [2:0] CAUSE_HOST    = 3'b100;
  localparam logic [2:0] CAUSE_BKPT    = 3'b101;

  localparam logic [CNT_W:0] TIMEOUT_W = (CNT_W+1)'(TIMEOUT);

  state_t     state;
  logic       ret_stopped;
  logic       core_en_q;
  logic       accept;
  logic       bkpt_hit;
  logic       en_eff;
  logic       halt_instr;
  logic       timeout_hit;
  logic       host_halt;
  logic       stop_now;
  logic [2:0] stop_code;
  logic       unused_bits;

`ifdef E15_BKPT_EN
  logic first_q;
  // The first instruction of a RUN may sit on the breakpoint; first_q lets it execute.
  assign bkpt_hit    = (state == S_RUN) && bkpt_en && (core_pc == bkpt_addr) && !first_q;
  assign unused_bits = ^core_instr[7:4];
`else
  assign bkpt_hit    = 1'b0;
  assign unused_bits = ^{core_instr[7:4], core_pc};
`endif

  // A breakpoint must suppress the very edge at which the PC reaches it, so it gates
  // the registered enable; without breakpoints core_en is purely the flop.
  assign en_eff    = core_en_q & ~bkpt_hit;
  assign core_en   = en_eff;
  assign cmd_ready = (state == S_IDLE) || (state == S_STOPPED) || (state == S_RUN);
  assign busy      = (state == S_LOAD) || (state == S_RUN) || (state == S_STEP);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    stop_now    = 1'b0;
    stop_code   = CAUSE_NONE;
    host_halt   = accept && (state == S_RUN) && (cmd_op == OP_HALT);
    halt_instr  = en_eff && (state == S_RUN) &&
                  (core_instr[11:8] == 4'b0000) && (core_instr[3:0] == 4'b0000);
    timeout_hit = en_eff && (state == S_RUN) && (({1'b0, cycle_cnt} + 1'b1) == TIMEOUT_W);
    if (host_halt) begin
      stop_now  = 1'b1;
      stop_code = CAUSE_HOST;
    end else if (bkpt_hit) begin
      stop_now  = 1'b1;
      stop_code = CAUSE_BKPT;
    end else if (halt_instr) begin
      stop_now  = 1'b1;
      stop_code = CAUSE_HINSTR;
    end else if (timeout_hit) begin
      stop_now  = 1'b1;
      stop_code = CAUSE_TIMEOUT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ret_stopped <= 1'b0;
      core_en_q   <= 1'b0;
      rom_we      <= 1'b0;
      rom_waddr   <= '0;
      rom_wdata   <= '0;
      stop_pulse  <= 1'b0;
      stop_cause  <= CAUSE_NONE;
      cycle_cnt   <= '0;
      cmd_err     <= 1'b0;
`ifdef E15_BKPT_EN
      first_q     <= 1'b0;
`endif
    end else begin
      rom_we     <= 1'b0;
      stop_pulse <= 1'b0;
      cmd_err    <= 1'b0;
      if (en_eff && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 1'b1;

      case (state)
        S_IDLE, S_STOPPED: begin
          if (accept) begin
            case (cmd_op)
              OP_LOAD: begin
                rom_we      <= 1'b1;
                rom_waddr   <= ld_addr;
                rom_wdata   <= ld_data;
                ret_stopped <= (state == S_STOPPED);
                state       <= S_LOAD;
              end
              OP_RUN: begin
                cycle_cnt  <= '0;
                stop_cause <= CAUSE_NONE;
                core_en_q  <= 1'b1;
                state      <= S_RUN;
`ifdef E15_BKPT_EN
                first_q    <= 1'b1;
`endif
              end
              OP_STEP: begin
                cycle_cnt  <= '0;
                stop_cause <= CAUSE_NONE;
                core_en_q  <= 1'b1;
                state      <= S_STEP;
              end
              default: ;
            endcase
          end
        end
        S_LOAD: state <= ret_stopped ? S_STOPPED : S_IDLE;
        S_STEP: begin
          core_en_q  <= 1'b0;
          stop_cause <= CAUSE_STEP;
          stop_pulse <= 1'b1;
          state      <= S_STOPPED;
        end
        S_RUN: begin
`ifdef E15_BKPT_EN
          if (en_eff) first_q <= 1'b0;
`endif
          if (accept && (cmd_op != OP_HALT)) cmd_err <= 1'b1;
          if (stop_now) begin
            core_en_q  <= 1'b0;
            stop_cause <= stop_code;
            stop_pulse <= 1'b1;
            state      <= S_STOPPED;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e15_run_ctrl.sv
// Directed bench for e15_run_ctrl with a tiny behavioural processor (16-word ROM, PC, jmp).
// Breakpoint scenarios are compiled in when E15_BKPT_EN is defined.
module tb_e15_run_ctrl;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [3:0]  ld_addr = 4'h0;
  logic [11:0] ld_data = 12'h000;
  logic        rom_we;
  logic [3:0]  rom_waddr;
  logic [11:0] rom_wdata;
  logic [3:0]  core_pc;
  logic [11:0] core_instr;
  logic        core_en;
  logic        busy;
  logic        stop_pulse;
  logic [2:0]  stop_cause;
  logic [7:0]  cycle_cnt;
  logic        cmd_err;
`ifdef E15_BKPT_EN
  logic        bkpt_en = 1'b0;
  logic [3:0]  bkpt_addr = 4'h0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  e15_run_ctrl #(.CNT_W(8), .TIMEOUT(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .rom_we     (rom_we),
    .rom_waddr  (rom_waddr),
    .rom_wdata  (rom_wdata),
    .core_pc    (core_pc),
    .core_instr (core_instr),
    .core_en    (core_en),
    .busy       (busy),
    .stop_pulse (stop_pulse),
    .stop_cause (stop_cause),
    .cycle_cnt  (cycle_cnt),
    .cmd_err    (cmd_err)
`ifdef E15_BKPT_EN
    ,
    .bkpt_en    (bkpt_en),
    .bkpt_addr  (bkpt_addr)
`endif
  );

  always #5 clk = ~clk;

  // Processor model: jmp (opcode 0) adds its 4-bit offset to the PC, others advance by one.
  logic [11:0] rom [16];
  logic [3:0]  pc;
  assign core_pc    = pc;
  assign core_instr = rom[pc];

  initial for (int i = 0; i < 16; i++) rom[i] = 12'h201;

  always @(posedge clk) if (rom_we) rom[rom_waddr] <= rom_wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 4'h0;
    else if (core_en) pc <= (rom[pc][11:8] == 4'h0) ? pc + rom[pc][3:0] : pc + 4'h1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [11:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    ld_addr   = a;
    ld_data   = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [11:0] d);
    issue(OP_LOAD, a, d);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts the current sample plus n further post-edge samples.
  task automatic measure(input int n, output int en_cnt, output int sp_cnt, output int we_cnt);
    en_cnt = int'(core_en);
    sp_cnt = int'(stop_pulse);
    we_cnt = int'(rom_we);
    for (int i = 0; i < n; i++) begin
      tick();
      en_cnt += int'(core_en);
      sp_cnt += int'(stop_pulse);
      we_cnt += int'(rom_we);
    end
  endtask

  initial begin
    int en_c, sp_c, we_c;

    // Reset state
    #3;
    check("rst_busy", busy, 0);
    check("rst_core_en", core_en, 0);
    check("rst_cause", stop_cause, 0);
    check("rst_cnt", cycle_cnt, 0);
    check("rst_waddr", rom_waddr, 0);
    check("rst_wdata", rom_wdata, 0);
    check("rst_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // LOAD addr 3 data 9A5
    issue(OP_LOAD, 4'd3, 12'h9A5);
    check("ld_we", rom_we, 1);
    check("ld_waddr", rom_waddr, 3);
    check("ld_wdata", rom_wdata, 12'h9A5);
    check("ld_ready_low", cmd_ready, 0);
    check("ld_busy", busy, 1);
    tick();
    check("ld_we_once", rom_we, 0);
    check("ld_ready_back", cmd_ready, 1);
    check("ld_idle", busy, 0);

    // movi, addi, jmp +0 (src/dst bits set) at PC 2
    load_word(4'd0, 12'h105);
    load_word(4'd1, 12'h201);
    load_word(4'd2, 12'h030);
    issue(OP_RUN, 4'd0, 12'h000);
    check("hi_busy", busy, 1);
    measure(30, en_c, sp_c, we_c);
    check("hi_en_cycles", en_c, 3);
    check("hi_pulses", sp_c, 1);
    check("hi_cause", stop_cause, 3'b010);
    check("hi_cnt", cycle_cnt, 3);
    check("hi_busy_end", busy, 0);

    // Timeout: addi; jmp -1 loop
    do_reset();
    load_word(4'd0, 12'h201);
    load_word(4'd1, 12'h00F);
    issue(OP_RUN, 4'd0, 12'h000);
    measure(40, en_c, sp_c, we_c);
    check("to_en_cycles", en_c, 20);
    check("to_pulses", sp_c, 1);
    check("to_cause", stop_cause, 3'b011);
    check("to_cnt", cycle_cnt, 20);

    // LOAD during RUN is dropped with cmd_err, run continues to timeout
    do_reset();
    issue(OP_RUN, 4'd0, 12'h000);
    tick();
    tick();
    issue(OP_LOAD, 4'd9, 12'h123);
    check("lr_err", cmd_err, 1);
    check("lr_we", rom_we, 0);
    check("lr_core_en", core_en, 1);
    tick();
    check("lr_err_once", cmd_err, 0);
    measure(40, en_c, sp_c, we_c);
    check("lr_no_we", we_c, 0);
    check("lr_cause", stop_cause, 3'b011);
    check("lr_cnt", cycle_cnt, 20);
    check("lr_rom9", rom[9], 12'h201);

    // HALT on the same edge the halt instruction is detected
    do_reset();
    load_word(4'd1, 12'h030);
    issue(OP_RUN, 4'd0, 12'h000);
    tick();
    check("hh_pc1", core_pc, 1);
    issue(OP_HALT, 4'd0, 12'h000);
    check("hh_cause", stop_cause, 3'b100);
    check("hh_no_err", cmd_err, 0);
    check("hh_pulse", stop_pulse, 1);
    check("hh_core_en", core_en, 0);
    check("hh_cnt", cycle_cnt, 2);

    // HALT while stopped is a no-op
    issue(OP_HALT, 4'd0, 12'h000);
    check("hs_no_err", cmd_err, 0);
    check("hs_cause", stop_cause, 3'b100);
    check("hs_busy", busy, 0);

    // STEP
    issue(OP_STEP, 4'd0, 12'h000);
    check("st_core_en", core_en, 1);
    check("st_busy", busy, 1);
    check("st_ready_low", cmd_ready, 0);
    check("st_cnt_clr", cycle_cnt, 0);
    tick();
    check("st_core_en_off", core_en, 0);
    check("st_pulse", stop_pulse, 1);
    check("st_cause", stop_cause, 3'b001);
    check("st_cnt", cycle_cnt, 1);
    tick();
    check("st_pulse_once", stop_pulse, 0);

    // LOAD from STOPPED returns to STOPPED and keeps the cause
    issue(OP_LOAD, 4'd1, 12'h201);
    check("ls_we", rom_we, 1);
    tick();
    check("ls_busy", busy, 0);
    check("ls_cause", stop_cause, 3'b001);
    check("ls_no_pulse", stop_pulse, 0);
    check("ls_ready", cmd_ready, 1);

    // Reset mid-RUN
    issue(OP_RUN, 4'd0, 12'h000);
    check("rr_running", core_en, 1);
    rst_n = 1'b0;
    #1;
    check("rr_core_en", core_en, 0);
    check("rr_busy", busy, 0);
    check("rr_cause", stop_cause, 0);
    check("rr_cnt", cycle_cnt, 0);
    measure(3, en_c, sp_c, we_c);
    check("rr_no_en", en_c, 0);
    // First command accepted at the first edge after release
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    ld_addr   = 4'd2;
    ld_data   = 12'h201;
    rst_n     = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("rr_first_cmd", rom_we, 1);
    tick();

`ifdef E15_BKPT_EN
    bkpt_en   = 1'b1;
    bkpt_addr = 4'd5;
    issue(OP_RUN, 4'd0, 12'h000);
    measure(30, en_c, sp_c, we_c);
    check("bk_en_cycles", en_c, 5);
    check("bk_cause", stop_cause, 3'b101);
    check("bk_pc", core_pc, 5);
    check("bk_cnt", cycle_cnt, 5);
    // Restart on the breakpoint address runs the full wrap back to it
    issue(OP_RUN, 4'd0, 12'h000);
    check("bk_first_en", core_en, 1);
    measure(30, en_c, sp_c, we_c);
    check("bk2_cnt", cycle_cnt, 16);
    check("bk2_cause", stop_cause, 3'b101);
    check("bk2_pc", core_pc, 5);
    bkpt_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/e15_run_ctrl.md
E15_RUN_CTRL -- requirements
Module: e15_run_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of the enabled-cycle counter.
REQ-002 The block SHALL have parameter TIMEOUT, default 200: maximum enabled cycles per RUN; legal range 1 to 2^CNT_W-1.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port cmd_valid, input, 1: host command valid.
REQ-006 The block SHALL have port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-007 The block SHALL have port cmd_op, input, 2: 00 LOAD, 01 RUN, 10 STEP, 11 HALT.
REQ-008 The block SHALL have ports ld_addr, input, 4 and ld_data, input, 12: the ROM word for LOAD.
REQ-009 The block SHALL have ports rom_we, output, 1; rom_waddr, output, 4; rom_wdata, output, 12: the program ROM write port.
REQ-010 The block SHALL have ports core_pc, input, 4 and core_instr, input, 12: the current PC and the fetched instruction from the processor.
REQ-011 The block SHALL have port core_en, output, 1: processor advances one instruction on each rising edge with core_en high.
REQ-012 The block SHALL have ports busy, output, 1; stop_pulse, output, 1; stop_cause, output, 3; cycle_cnt, output, CNT_W; cmd_err, output, 1.

Function
REQ-013 The block SHALL implement the states IDLE, LOAD, RUN, STEP and STOPPED, with busy high in LOAD, RUN and STEP.
REQ-014 cmd_ready SHALL be high in IDLE, STOPPED and RUN, and low in LOAD and STEP.
REQ-015 In IDLE or STOPPED, an accepted LOAD SHALL enter LOAD for exactly 1 cycle with rom_we=1, rom_waddr=ld_addr and rom_wdata=ld_data registered at acceptance, then return to the prior state.
REQ-016 In IDLE or STOPPED, an accepted RUN SHALL clear cycle_cnt and stop_cause, enter RUN, and drive core_en=1 from the next cycle.
REQ-017 In IDLE or STOPPED, an accepted STEP SHALL clear cycle_cnt, enter STEP, drive core_en=1 for exactly 1 cycle, then enter STOPPED with cause 001.
REQ-018 In RUN, an accepted HALT SHALL clear core_en next cycle and enter STOPPED with cause 100.
REQ-019 In RUN, an accepted LOAD, RUN or STEP SHALL be dropped, with cmd_err pulsed high for 1 cycle.
REQ-020 An accepted HALT in IDLE or STOPPED SHALL be a no-op with no cmd_err.
REQ-021 Halt-instruction detect: in RUN with core_en=1, core_instr[11:8]==4'b0000 and core_instr[3:0]==4'b0000 (jmp +0, src/dst ignored) SHALL clear core_en next cycle and enter STOPPED with cause 010.
REQ-022 The self-jump edge at which the halt instruction is detected SHALL execute harmlessly.
REQ-023 cycle_cnt SHALL increment on every edge with core_en=1, saturating at 2^CNT_W-1.
REQ-024 Timeout: the edge that brings cycle_cnt to TIMEOUT while in RUN SHALL also clear core_en and enter STOPPED with cause 011, so core_en is high for exactly TIMEOUT cycles.
REQ-025 Simultaneous stop events SHALL resolve by priority host HALT > breakpoint > halt-instruction > timeout; only the winning cause is recorded.
REQ-026 stop_pulse SHALL be high for exactly the first cycle in STOPPED.
REQ-027 stop_cause SHALL hold its value until the next accepted RUN or STEP, or until reset.
REQ-028 Stop cause encoding SHALL be: 000 none, 001 step, 010 halt-instr, 011 timeout, 100 host halt, 101 breakpoint.
REQ-029 core_en, rom_we, stop_pulse and cmd_err SHALL be registered outputs.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, with core_en, rom_we, stop_pulse and cmd_err at 0.
REQ-031 rst_n low SHALL immediately force busy=0, stop_cause=000, cycle_cnt=0, rom_waddr=0 and rom_wdata=0.
REQ-032 Reset asserted mid-RUN or mid-LOAD SHALL abort that operation with no further core_en or rom_we pulse.
REQ-033 After rst_n deasserts, the first command SHALL be accepted at the next rising edge.

Configuration
REQ-034 When macro E15_BKPT_EN is defined, the block SHALL add ports bkpt_en, input, 1 and bkpt_addr, input, 4.
REQ-035 With E15_BKPT_EN defined, in RUN with bkpt_en=1 and core_pc==bkpt_addr, core_en SHALL be low that cycle (the instruction at bkpt_addr is not executed) and the block SHALL enter STOPPED with cause 101.
REQ-036 With E15_BKPT_EN defined, a STEP or RUN started at the breakpoint address SHALL execute its first instruction without matching the breakpoint.
REQ-037 Without E15_BKPT_EN, the breakpoint ports and logic SHALL be absent and cause 101 SHALL never occur.

Verification
REQ-038 Bench SHALL cover: LOAD addr 3 data 12'h9A5 -> rom_we high for exactly 1 cycle with rom_waddr=3 and rom_wdata=12'h9A5, cmd_ready low that cycle.
REQ-039 Bench SHALL cover: program movi, addi, then jmp +0 at PC 2, then RUN -> core_en high 3 cycles, stop_cause=010, cycle_cnt=3, 1-cycle stop_pulse.
REQ-040 Bench SHALL cover: TIMEOUT=20, loop jmp 4'hF, RUN -> core_en high exactly 20 cycles, stop_cause=011, cycle_cnt=20.
REQ-041 Bench SHALL cover: HALT issued during RUN on the same cycle as the halt-instruction detect -> stop_cause=100, no cmd_err.
REQ-042 Bench SHALL cover: LOAD issued during RUN -> cmd_err pulses 1 cycle, rom_we stays 0, and the run continues.
REQ-043 Bench SHALL cover: rst_n pulsed low mid-RUN -> core_en=0 in the same cycle, state IDLE, stop_cause=000; with E15_BKPT_EN, bkpt_addr=5 -> stop with core_pc=5 and cause 101.
